// File: rtl/rv32i_ifetch_if.sv
// Instruction-memory fetch bus: request/ack handshake carrying a word address and the returned word.
interface rv32i_ifetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/rv32i_ifetch.sv
// RV32I fetch stage: owns the PC, fetches over the imem handshake and keeps a one-entry
// instruction buffer for decode; redirects flush the buffer and drop in-flight words.
module rv32i_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  rv32i_ifetch_if.master        imem,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  input  logic                  stall_i,
  output logic [31:0]           instr_o,
  output logic [31:0]           pc_o,
  output logic                  valid_o,
  output logic                  misalign_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_FULL = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_r, state_n;
  logic [31:0] pc_r, pc_n;
  logic [31:0] drop_addr_r, drop_addr_n;
  logic [31:0] instr_r, instr_n;
  logic [31:0] pcbuf_r, pcbuf_n;
  logic        valid_r, valid_n;
  logic        misalign_r, misalign_n;
  logic        req_raw_s;
  logic        req_s;
  logic        ack_s;

  // Request level per state; a stalled full buffer needs no new word yet.
  always_comb begin
    req_raw_s = 1'b0;
    case (state_r)
      S_REQ:   req_raw_s = 1'b1;
      S_FULL:  req_raw_s = ~stall_i;
      S_DROP:  req_raw_s = 1'b1;
      default: req_raw_s = 1'b0;
    endcase
  end

  assign req_s      = req_raw_s & ~rst_i;
  assign ack_s      = req_s & imem.ack;
  assign imem.req   = req_s;
  // While dropping, the address of the abandoned fetch must stay on the bus until it is acked.
  assign imem.addr  = (state_r == S_DROP) ? drop_addr_r : pc_r;

  assign instr_o    = instr_r;
  assign pc_o       = pcbuf_r;
  assign valid_o    = valid_r;
  assign misalign_o = misalign_r;

  // Next-state and buffer update; redirect overrides everything, including stall.
  always_comb begin
    state_n     = state_r;
    pc_n        = pc_r;
    drop_addr_n = drop_addr_r;
    instr_n     = instr_r;
    pcbuf_n     = pcbuf_r;
    valid_n     = valid_r;
    misalign_n  = misalign_r;

    if (redirect_i) begin
      valid_n    = 1'b0;
      pc_n       = {redirect_pc_i[31:2], 2'b00};
      misalign_n = |redirect_pc_i[1:0];
      if (state_r == S_DROP) begin
        state_n = ack_s ? S_REQ : S_DROP;
      end else if (req_s && !ack_s) begin
        state_n     = S_DROP;
        drop_addr_n = pc_r;
      end else begin
        state_n = S_REQ;
      end
    end else begin
      case (state_r)
        S_REQ: begin
          if (ack_s) begin
            instr_n = imem.rdata;
            pcbuf_n = pc_r;
            valid_n = 1'b1;
            pc_n    = pc_r + 32'd4;
            state_n = S_FULL;
          end else begin
            valid_n = 1'b0;
          end
        end
        S_FULL: begin
          if (stall_i) begin
            state_n = S_FULL;
          end else if (ack_s) begin
            instr_n = imem.rdata;
            pcbuf_n = pc_r;
            valid_n = 1'b1;
            pc_n    = pc_r + 32'd4;
          end else begin
            valid_n = 1'b0;
            state_n = S_REQ;
          end
        end
        S_DROP: begin
          if (ack_s) begin
            state_n = S_REQ;
          end else begin
            state_n = S_DROP;
          end
        end
        default: begin
          valid_n = 1'b0;
          state_n = S_REQ;
        end
      endcase
    end
  end

  // State and buffer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= S_REQ;
      pc_r        <= RESET_PC;
      drop_addr_r <= RESET_PC;
      instr_r     <= NOP;
      pcbuf_r     <= RESET_PC;
      valid_r     <= 1'b0;
      misalign_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      pc_r        <= pc_n;
      drop_addr_r <= drop_addr_n;
      instr_r     <= instr_n;
      pcbuf_r     <= pcbuf_n;
      valid_r     <= valid_n;
      misalign_r  <= misalign_n;
    end
  end

endmodule

// File: tb/tb_rv32i_ifetch.sv
// Bench for rv32i_ifetch: latency-programmable memory model, in-order scoreboard of expected
// fetch addresses, a redirect vector table and hand-written stall/drop/reset sequences.
module tb_rv32i_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] rpc;
  logic        stall;
  logic        force_ack;
  int          lat;
  int          cnt = 0;

  logic [31:0] instr, pc, w_instr, w_pc;
  logic        valid, mis, w_valid, w_mis;

  int errors = 0;
  int checks = 0;
  int consumed = 0;
  logic [31:0] sbq[$];

  typedef struct {
    logic [31:0] rpc;
    logic        stall;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;
  vec_t vecs[5];

  rv32i_ifetch_if bus ();
  rv32i_ifetch_if wbus ();

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  always #5 clk = ~clk;

  assign bus.ack    = (bus.req && (cnt >= lat)) || force_ack;
  assign bus.rdata  = force_ack ? 32'hDEAD_BEEF : memfn(bus.addr);
  assign wbus.ack   = wbus.req;
  assign wbus.rdata = memfn(wbus.addr);

  always @(posedge clk) begin
    if (!bus.req || (cnt >= lat)) cnt <= 0;
    else cnt <= cnt + 1;
  end

  rv32i_ifetch dut (
    .clk_i(clk), .rst_i(rst), .imem(bus),
    .redirect_i(redirect), .redirect_pc_i(rpc), .stall_i(stall),
    .instr_o(instr), .pc_o(pc), .valid_o(valid), .misalign_o(mis)
  );

  rv32i_ifetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk_i(clk), .rst_i(rst), .imem(wbus),
    .redirect_i(1'b0), .redirect_pc_i(32'h0000_0000), .stall_i(1'b0),
    .instr_o(w_instr), .pc_o(w_pc), .valid_o(w_valid), .misalign_o(w_mis)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got none expected event", name);
  endtask

  task automatic sb_reset(input logic [31:0] start);
    sbq.delete();
    for (int i = 0; i < 64; i++) sbq.push_back(start + 32'(4 * i));
  endtask

  // Scoreboard: every word the consumer takes must be the next expected address in order.
  task automatic mon();
    logic [31:0] e;
    if (!rst && !redirect && valid && !stall) begin
      if (sbq.size() == 0) begin
        fail("sb_empty");
      end else begin
        e = sbq.pop_front();
        chk("sb_pc", pc, e);
        chk("sb_instr", instr, memfn(e));
        consumed++;
      end
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    mon();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    nxt();
    adv();
  endtask

  initial begin
    int c0;
    bit got;
    vecs[0] = '{32'h0000_0102, 1'b0, 32'h0000_0100, 1'b1};
    vecs[1] = '{32'h0000_0200, 1'b0, 32'h0000_0200, 1'b0};
    vecs[2] = '{32'h0000_1000, 1'b1, 32'h0000_1000, 1'b0};
    vecs[3] = '{32'h0000_0203, 1'b1, 32'h0000_0200, 1'b1};
    vecs[4] = '{32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFC, 1'b1};

    rst = 1'b1; redirect = 1'b0; rpc = 32'h0; stall = 1'b0; force_ack = 1'b0; lat = 0;
    adv();

    // Reset state and first fetch after release; second instance shows PC wrap-around.
    nxt();
    chk("rst_req", {31'b0, bus.req}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_mis", {31'b0, mis}, 32'd0);
    chk("w_rst_pc", w_pc, 32'hFFFF_FFF8);
    adv();
    rst = 1'b0;
    sb_reset(32'h0);
    nxt();
    chk("t1_req", {31'b0, bus.req}, 32'd1);
    chk("t1_addr", bus.addr, 32'h0);
    chk("t1_valid0", {31'b0, valid}, 32'd0);
    chk("w_valid0", {31'b0, w_valid}, 32'd0);
    adv();
    nxt();
    chk("t1_valid1", {31'b0, valid}, 32'd1);
    chk("w_valid1", {31'b0, w_valid}, 32'd1);
    chk("w_pc0", w_pc, 32'hFFFF_FFF8);
    adv();
    nxt();
    chk("w_pc1", w_pc, 32'hFFFF_FFFC);
    adv();
    nxt();
    chk("w_pc2", w_pc, 32'h0000_0000);
    chk("w_instr2", w_instr, memfn(32'h0));
    chk("w_mis", {31'b0, w_mis}, 32'd0);
    adv();
    repeat (4) tick();

    // Stall holds the buffer and suppresses requests; an ack with no request is ignored.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("t2_req", {31'b0, bus.req}, 32'd0);
      chk("t2_valid", {31'b0, valid}, 32'd1);
      chk("t2_pc", pc, sbq[0]);
      chk("t2_instr", instr, memfn(sbq[0]));
      adv();
      force_ack = (i == 0);
    end
    force_ack = 1'b0;
    stall = 1'b0;
    c0 = consumed;
    repeat (4) tick();
    chk("t2_resume", 32'(consumed - c0), 32'd4);

    // Slow memory: redirect while the fetch of 0x8 is outstanding.
    lat = 3;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_reset(32'h0);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      nxt();
      if (bus.req && bus.addr == 32'h8 && cnt == 0) got = 1'b1;
      adv();
      if (got) break;
    end
    if (!got) fail("t3_wait_fetch8");
    redirect = 1'b1;
    rpc = 32'h0000_0100;
    sb_reset(32'h0000_0100);
    nxt();
    chk("t3_addr_redir", bus.addr, 32'h8);
    adv();
    redirect = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      nxt();
      chk("t3_drop_addr", bus.addr, 32'h8);
      if (bus.ack) got = 1'b1;
      adv();
      if (got) break;
    end
    if (!got) fail("t3_drop_ack");
    nxt();
    chk("t3_new_addr", bus.addr, 32'h0000_0100);
    chk("t3_new_req", {31'b0, bus.req}, 32'd1);
    chk("t3_mis", {31'b0, mis}, 32'd0);
    adv();
    c0 = consumed;
    repeat (12) tick();
    chk("t3_progress", {31'b0, consumed > c0}, 32'd1);

    // Redirect table on zero-wait memory: alignment, misalign flag, latency, stall overlap.
    lat = 0;
    repeat (2) tick();
    foreach (vecs[v]) begin
      redirect = 1'b1;
      rpc = vecs[v].rpc;
      stall = vecs[v].stall;
      sb_reset(vecs[v].exp_pc);
      nxt();
      adv();
      redirect = 1'b0;
      stall = 1'b0;
      got = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        nxt();
        if (valid && !got) begin
          chk("t4_latency", 32'(k), 32'd2);
          chk("t4_mis", {31'b0, mis}, {31'b0, vecs[v].exp_mis});
          got = 1'b1;
        end
        adv();
        if (got) break;
      end
      if (!got) fail("t4_valid");
      repeat (3) tick();
      nxt();
      chk("t4_mis_sticky", {31'b0, mis}, {31'b0, vecs[v].exp_mis});
      adv();
    end

    // Reset with a fetch in flight and a stray ack during the reset cycle.
    lat = 3;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      nxt();
      if (bus.req && !bus.ack && cnt == 1) got = 1'b1;
      adv();
      if (got) break;
    end
    if (!got) fail("t6_wait_inflight");
    rst = 1'b1;
    force_ack = 1'b1;
    nxt();
    chk("t6_rst_req", {31'b0, bus.req}, 32'd0);
    adv();
    rst = 1'b0;
    force_ack = 1'b0;
    sb_reset(32'h0);
    nxt();
    chk("t6_valid", {31'b0, valid}, 32'd0);
    chk("t6_pc", pc, 32'h0000_0000);
    chk("t6_instr", instr, 32'h0000_0013);
    chk("t6_mis", {31'b0, mis}, 32'd0);
    chk("t6_addr", bus.addr, 32'h0000_0000);
    adv();
    c0 = consumed;
    repeat (12) tick();
    chk("t6_progress", {31'b0, consumed > c0}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
